i2c_byte_ctrl: RTL
==================

Name: i2c_byte_ctrl

Overview:
Byte-level I2C master command sequencer that sits directly upstream of the I2C bit-level PHY FSM. It accepts byte commands (start, write, read, stop) from the register/host interface and breaks each into a sequence of bit commands. It shifts data MSB-first and handles the ACK/NACK bit. It reports completion, the received byte, the received ACK and arbitration loss back to the host.

Parameters:
CMD_NOP, 4'h0, bit command: no operation
CMD_START, 4'h1, bit command: START/repeated START
CMD_STOP, 4'h2, bit command: STOP
CMD_WRITE, 4'h4, bit command: write one bit
CMD_READ, 4'h8, bit command: read one bit

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  host: generate START before the byte
stop  in  1  host: generate STOP after the byte
read  in  1  host: read a byte
write  in  1  host: write a byte
ack_in  in  1  host: ACK bit to send after a read (0=ACK, 1=NACK)
din  in  8  host: byte to transmit
cmd_ack  out  1  host: one-cycle pulse, command sequence complete
ack_out  out  1  host: ACK bit received after a write (0=ACK)
dout  out  8  host: received byte
i2c_al  out  1  host: one-cycle pulse, arbitration lost
core_cmd  out  4  PHY bit command
core_txd  out  1  PHY bit to drive on SDA
core_ack  in  1  PHY bit command complete (one-cycle pulse)
core_rxd  in  1  PHY bit sampled on SDA
core_al  in  1  PHY arbitration lost

Behaviour:
- Reset (async, rstn low): state=IDLE, core_cmd=CMD_NOP, core_txd=0, cmd_ack=0, i2c_al=0, ack_out=0, dout=8'h00, shift reg=0, bit cnt=0. Reset mid-sequence aborts with no cmd_ack.
- go = (start|stop|read|write) & ~cmd_ack. Sampled only in IDLE.
- The host holds command bits until cmd_ack and clears them in the next cycle.
- States: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE + go:
  - start -> START, core_cmd=CMD_START.
  - else write -> WRITE, core_cmd=CMD_WRITE, core_txd=din[7].
  - else read -> READ, core_cmd=CMD_READ, core_txd=1.
  - else stop -> STOP, core_cmd=CMD_STOP.
  - Priority is start > write > read > stop. If write and read are both set, write wins.
- On entry to WRITE or READ: shift reg loaded from din (write) or left as is (read); cnt=7.
- core_cmd/core_txd are registered and held stable until core_ack. The next bit command is loaded on the same edge that samples core_ack, so the PHY sees it when it returns to idle. There are no NOP gaps within a sequence.
- START + core_ack:
  - write -> WRITE, core_txd=din[7].
  - else read -> READ.
  - else stop -> STOP.
  - else -> IDLE with cmd_ack.
- WRITE, each core_ack: shift left, cnt-1, core_txd=next MSB.
  - core_ack with cnt==0 -> ACK, core_cmd=CMD_READ, core_txd=1.
- READ, each core_ack: shift in core_rxd at LSB, cnt-1.
  - core_ack with cnt==0 -> ACK, core_cmd=CMD_WRITE, core_txd=ack_in.
  - dout takes the completed 8-bit byte on that edge.
- ACK + core_ack:
  - ack_out<=core_rxd, updated only when the byte was a write.
  - stop -> STOP, core_cmd=CMD_STOP.
  - else -> IDLE, core_cmd=CMD_NOP, cmd_ack pulse.
- STOP + core_ack -> IDLE, core_cmd=CMD_NOP, cmd_ack pulse.
- cmd_ack is registered: high exactly one cycle, on the cycle after the final core_ack.
- core_al high in any state (including simultaneous with core_ack):
  - -> IDLE, core_cmd=CMD_NOP, core_txd=0, cnt=0.
  - i2c_al pulses 1 cycle. cmd_ack is not asserted.
  - dout and ack_out keep their old values.
- core_ack in IDLE is ignored.
- cnt is 3-bit with no wrap: it is reloaded to 7 on every WRITE/READ entry.

Test Plan:
- start+write, din=8'hA5, PHY model acks each bit, slave ACK=0 -> core_cmd sequence START, WRITE x8 with txd 1,0,1,0,0,1,0,1, READ; cmd_ack one cycle after 10th core_ack; ack_out=0.
- read+ack_in=1+stop, slave bits 8'h3C -> READ x8, WRITE txd=1, STOP; dout=8'h3C; cmd_ack after STOP ack.
- write only, din=8'hFF, slave NACK -> ack_out=1; no START/STOP issued; cmd_ack pulse.
- stop only -> single CMD_STOP; cmd_ack 1 cycle after core_ack; state IDLE, core_cmd=NOP.
- core_al asserted during 4th WRITE bit of 8'h5A -> i2c_al one-cycle pulse, core_cmd=NOP next cycle, no cmd_ack, dout unchanged; subsequent write of 8'h11 completes normally.
- rstn pulsed low mid-READ -> all outputs at reset values immediately; start+read afterwards begins with CMD_START.

Source files
------------

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: turns host start/write/read/stop byte commands
// into PHY bit commands, shifting MSB-first and handling the ACK bit.
module i2c_byte_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       i2c_al,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd,
  input  logic       core_al
);

  localparam logic [3:0] CMD_NOP   = 4'h0;
  localparam logic [3:0] CMD_START = 4'h1;
  localparam logic [3:0] CMD_STOP  = 4'h2;
  localparam logic [3:0] CMD_WRITE = 4'h4;
  localparam logic [3:0] CMD_READ  = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_ACK,
    ST_STOP
  } state_t;

  state_t     r_state;
  logic [3:0] r_core_cmd;
  logic       r_core_txd;
  logic       r_cmd_ack;
  logic       r_i2c_al;
  logic       r_ack_out;
  logic [7:0] r_dout;
  logic [6:0] r_sr;
  logic [2:0] r_cnt;
  logic       r_is_wr;

  logic       w_go;
  logic [6:0] w_sr_nxt;

  assign w_go     = (start | stop | read | write) & ~r_cmd_ack;
  // The MSB of a write byte goes straight to core_txd, so only 7 bits need storing;
  // the same shift serves both directions (rxd enters at the LSB).
  assign w_sr_nxt = {r_sr[5:0], core_rxd};

  assign cmd_ack  = r_cmd_ack;
  assign ack_out  = r_ack_out;
  assign dout     = r_dout;
  assign i2c_al   = r_i2c_al;
  assign core_cmd = r_core_cmd;
  assign core_txd = r_core_txd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_core_cmd <= CMD_NOP;
      r_core_txd <= 1'b0;
      r_cmd_ack  <= 1'b0;
      r_i2c_al   <= 1'b0;
      r_ack_out  <= 1'b0;
      r_dout     <= 8'h00;
      r_sr       <= 7'h00;
      r_cnt      <= 3'd0;
      r_is_wr    <= 1'b0;
    end else begin
      r_cmd_ack <= 1'b0;
      r_i2c_al  <= 1'b0;
      if (core_al) begin
        // Arbitration loss overrides everything, including a coincident core_ack.
        r_state    <= ST_IDLE;
        r_core_cmd <= CMD_NOP;
        r_core_txd <= 1'b0;
        r_cnt      <= 3'd0;
        r_i2c_al   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_go) begin
              if (start) begin
                r_state    <= ST_START;
                r_core_cmd <= CMD_START;
              end else if (write) begin
                r_state    <= ST_WRITE;
                r_core_cmd <= CMD_WRITE;
                r_core_txd <= din[7];
                r_sr       <= din[6:0];
                r_cnt      <= 3'd7;
                r_is_wr    <= 1'b1;
              end else if (read) begin
                r_state    <= ST_READ;
                r_core_cmd <= CMD_READ;
                r_core_txd <= 1'b1;
                r_cnt      <= 3'd7;
                r_is_wr    <= 1'b0;
              end else begin
                r_state    <= ST_STOP;
                r_core_cmd <= CMD_STOP;
              end
            end
          end
          ST_START: begin
            if (core_ack) begin
              if (write) begin
                r_state    <= ST_WRITE;
                r_core_cmd <= CMD_WRITE;
                r_core_txd <= din[7];
                r_sr       <= din[6:0];
                r_cnt      <= 3'd7;
                r_is_wr    <= 1'b1;
              end else if (read) begin
                r_state    <= ST_READ;
                r_core_cmd <= CMD_READ;
                r_core_txd <= 1'b1;
                r_cnt      <= 3'd7;
                r_is_wr    <= 1'b0;
              end else if (stop) begin
                r_state    <= ST_STOP;
                r_core_cmd <= CMD_STOP;
              end else begin
                r_state    <= ST_IDLE;
                r_core_cmd <= CMD_NOP;
                r_cmd_ack  <= 1'b1;
              end
            end
          end
          ST_WRITE: begin
            if (core_ack) begin
              r_sr <= w_sr_nxt;
              if (r_cnt == 3'd0) begin
                r_state    <= ST_ACK;
                r_core_cmd <= CMD_READ;
                r_core_txd <= 1'b1;
              end else begin
                r_cnt      <= r_cnt - 3'd1;
                r_core_txd <= r_sr[6];
              end
            end
          end
          ST_READ: begin
            if (core_ack) begin
              r_sr <= w_sr_nxt;
              if (r_cnt == 3'd0) begin
                r_state    <= ST_ACK;
                r_core_cmd <= CMD_WRITE;
                r_core_txd <= ack_in;
                r_dout     <= {r_sr, core_rxd};
              end else begin
                r_cnt <= r_cnt - 3'd1;
              end
            end
          end
          ST_ACK: begin
            if (core_ack) begin
              if (r_is_wr) begin
                r_ack_out <= core_rxd;
              end
              if (stop) begin
                r_state    <= ST_STOP;
                r_core_cmd <= CMD_STOP;
              end else begin
                r_state    <= ST_IDLE;
                r_core_cmd <= CMD_NOP;
                r_cmd_ack  <= 1'b1;
              end
            end
          end
          ST_STOP: begin
            if (core_ack) begin
              r_state    <= ST_IDLE;
              r_core_cmd <= CMD_NOP;
              r_cmd_ack  <= 1'b1;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_core_cmd <= CMD_NOP;
          end
        endcase
      end
    end
  end

endmodule
